// File: rtl/axi_mem_width_adapter.sv
// AXI4 narrow-to-wide data upsizer: AW/AR/B pass straight through, W/R data is steered per beat
// from a per-direction tracker FIFO plus beat-address engine. No added latency on any channel.

module axi_mwa_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end
endmodule

module axi_mem_width_adapter #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 28,
  parameter int NARROW_W    = 64,
  parameter int WIDE_W      = 128,
  parameter int OUTSTANDING = 4,
  parameter int REPLICATE   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ID_W-1:0]       s_awid_i,
  input  logic [ADDR_W-1:0]     s_awaddr_i,
  input  logic [7:0]            s_awlen_i,
  input  logic [2:0]            s_awsize_i,
  input  logic [1:0]            s_awburst_i,
  input  logic                  s_awlock_i,
  input  logic [3:0]            s_awcache_i,
  input  logic [2:0]            s_awprot_i,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [NARROW_W-1:0]   s_wdata_i,
  input  logic [NARROW_W/8-1:0] s_wstrb_i,
  input  logic                  s_wlast_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  output logic [ID_W-1:0]       s_bid_o,
  output logic [1:0]            s_bresp_o,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  input  logic [ID_W-1:0]       s_arid_i,
  input  logic [ADDR_W-1:0]     s_araddr_i,
  input  logic [7:0]            s_arlen_i,
  input  logic [2:0]            s_arsize_i,
  input  logic [1:0]            s_arburst_i,
  input  logic                  s_arlock_i,
  input  logic [3:0]            s_arcache_i,
  input  logic [2:0]            s_arprot_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [ID_W-1:0]       s_rid_o,
  output logic [NARROW_W-1:0]   s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rlast_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [ID_W-1:0]       m_awid_o,
  output logic [ADDR_W-1:0]     m_awaddr_o,
  output logic [7:0]            m_awlen_o,
  output logic [2:0]            m_awsize_o,
  output logic [1:0]            m_awburst_o,
  output logic                  m_awlock_o,
  output logic [3:0]            m_awcache_o,
  output logic [2:0]            m_awprot_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [WIDE_W-1:0]     m_wdata_o,
  output logic [WIDE_W/8-1:0]   m_wstrb_o,
  output logic                  m_wlast_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [ID_W-1:0]       m_bid_i,
  input  logic [1:0]            m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic [ID_W-1:0]       m_arid_o,
  output logic [ADDR_W-1:0]     m_araddr_o,
  output logic [7:0]            m_arlen_o,
  output logic [2:0]            m_arsize_o,
  output logic [1:0]            m_arburst_o,
  output logic                  m_arlock_o,
  output logic [3:0]            m_arcache_o,
  output logic [2:0]            m_arprot_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [ID_W-1:0]       m_rid_i,
  input  logic [WIDE_W-1:0]     m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rlast_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o
);
  localparam int NBYTES = NARROW_W / 8;
  localparam int LB     = $clog2(WIDE_W / 8);
  localparam int NB     = $clog2(NARROW_W / 8);
  localparam int RATIO  = WIDE_W / NARROW_W;

  typedef struct packed {
    logic [LB-1:0] addr;
    logic [2:0]    size;
    logic [7:0]    len;
    logic [1:0]    burst;
  } trk_t;

  function automatic logic [LB-1:0] next_addr(input logic [LB-1:0] a, input trk_t t);
    logic [LB-1:0] step, mask;
    step = LB'(1) << t.size;
    mask = LB'(((16'(t.len) + 16'd1) << t.size) - 16'd1);
    case (t.burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
      default: next_addr = a + step;
    endcase
  endfunction

  // ---------------- write path ----------------
  trk_t          wh, wpush;
  logic          w_full, w_empty, aw_push, w_hs, w_pop;
  logic [LB-1:0] waddr_q, waddr_d, wcur;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [LB-NB-1:0] wlane;

  assign m_awid_o    = s_awid_i;
  assign m_awaddr_o  = s_awaddr_i;
  assign m_awlen_o   = s_awlen_i;
  assign m_awsize_o  = s_awsize_i;
  assign m_awburst_o = s_awburst_i;
  assign m_awlock_o  = s_awlock_i;
  assign m_awcache_o = s_awcache_i;
  assign m_awprot_o  = s_awprot_i;
  assign m_awvalid_o = s_awvalid_i & ~w_full & ~rst_i;
  assign s_awready_o = m_awready_i & ~w_full & ~rst_i;
  assign aw_push     = s_awvalid_i & s_awready_o;
  assign wpush       = '{addr: s_awaddr_i[LB-1:0], size: s_awsize_i, len: s_awlen_i, burst: s_awburst_i};

  axi_mwa_fifo #(.W($bits(trk_t)), .DEPTH(OUTSTANDING)) u_wfifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(aw_push), .din_i(wpush),
    .pop_i(w_pop), .dout_o(wh), .full_o(w_full), .empty_o(w_empty)
  );

  assign m_wvalid_o = s_wvalid_i & ~w_empty & ~rst_i;
  assign s_wready_o = m_wready_i & ~w_empty & ~rst_i;
  assign w_hs       = s_wvalid_i & s_wready_o;
  assign w_pop      = w_hs & s_wlast_i;
  // Beat 0 takes its address straight from the FIFO head; later beats use the engine.
  assign wcur       = (wcnt_q == 8'd0) ? wh.addr : waddr_q;
  assign wlane      = wcur[LB-1:NB];
  assign m_wdata_o  = {RATIO{s_wdata_i}};
  assign m_wstrb_o  = {{(WIDE_W/8-NBYTES){1'b0}}, s_wstrb_i} << (int'(wlane) * NBYTES);
  assign m_wlast_o  = s_wlast_i;

  always_comb begin
    waddr_d = waddr_q;
    wcnt_d  = wcnt_q;
    if (w_hs) begin
      waddr_d = next_addr(wcur, wh);
      wcnt_d  = s_wlast_i ? 8'd0 : wcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waddr_q <= '0;
      wcnt_q  <= '0;
    end else begin
      waddr_q <= waddr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign s_bid_o    = m_bid_i;
  assign s_bresp_o  = m_bresp_i;
  assign s_bvalid_o = m_bvalid_i & ~rst_i;
  assign m_bready_o = s_bready_i & ~rst_i;

  // ---------------- read path ----------------
  trk_t          rh, rpush;
  logic          r_full, r_empty, ar_push, r_hs, r_pop;
  logic [LB-1:0] raddr_q, raddr_d, rcur;
  logic [7:0]    rcnt_q, rcnt_d;
  logic [LB-NB-1:0] rlane;
  logic [NARROW_W-1:0] rraw, rshift, rdata;

  assign m_arid_o    = s_arid_i;
  assign m_araddr_o  = s_araddr_i;
  assign m_arlen_o   = s_arlen_i;
  assign m_arsize_o  = s_arsize_i;
  assign m_arburst_o = s_arburst_i;
  assign m_arlock_o  = s_arlock_i;
  assign m_arcache_o = s_arcache_i;
  assign m_arprot_o  = s_arprot_i;
  assign m_arvalid_o = s_arvalid_i & ~r_full & ~rst_i;
  assign s_arready_o = m_arready_i & ~r_full & ~rst_i;
  assign ar_push     = s_arvalid_i & s_arready_o;
  assign rpush       = '{addr: s_araddr_i[LB-1:0], size: s_arsize_i, len: s_arlen_i, burst: s_arburst_i};

  axi_mwa_fifo #(.W($bits(trk_t)), .DEPTH(OUTSTANDING)) u_rfifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(ar_push), .din_i(rpush),
    .pop_i(r_pop), .dout_o(rh), .full_o(r_full), .empty_o(r_empty)
  );

  assign m_rready_o = s_rready_i & ~r_empty & ~rst_i;
  assign s_rvalid_o = m_rvalid_i & ~r_empty & ~rst_i;
  assign s_rid_o    = m_rid_i;
  assign s_rresp_o  = m_rresp_i;
  assign s_rlast_o  = m_rlast_i;
  assign r_hs       = m_rvalid_i & m_rready_o;
  assign r_pop      = r_hs & m_rlast_i;
  assign rcur       = (rcnt_q == 8'd0) ? rh.addr : raddr_q;
  assign rlane      = rcur[LB-1:NB];
  assign rraw       = m_rdata_i[int'(rlane) * NARROW_W +: NARROW_W];
  assign rshift     = rraw >> (int'(rcur[NB-1:0]) * 8);
  assign s_rdata_o  = rdata;

  always_comb begin
    rdata = rraw;
    if (REPLICATE != 0 && int'(rh.size) < NB) begin
      for (int i = 0; i < NBYTES; i++) begin
        rdata[i*8 +: 8] = rshift[(i & ((1 << rh.size) - 1)) * 8 +: 8];
      end
    end
  end

  always_comb begin
    raddr_d = raddr_q;
    rcnt_d  = rcnt_q;
    if (r_hs) begin
      raddr_d = next_addr(rcur, rh);
      rcnt_d  = m_rlast_i ? 8'd0 : rcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      rcnt_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Protocol errors are forwarded untouched; these only flag them.
  a_wlast_len: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_hs && s_wlast_i) |-> (wcnt_q == wh.len));
  a_aw_size: assert property (@(posedge clk_i) disable iff (rst_i)
    aw_push |-> (int'(s_awsize_i) <= NB));
  a_ar_size: assert property (@(posedge clk_i) disable iff (rst_i)
    ar_push |-> (int'(s_arsize_i) <= NB));
endmodule

// File: tb/tb_axi_mem_width_adapter.sv
// Randomized bench for axi_mem_width_adapter; the testbench plays both the narrow master and the
// wide slave, and predicts steered data from burst address arithmetic.
module tb_axi_mem_width_adapter;
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic [3:0]   s_awid_i, s_arid_i, s_bid_o, s_rid_o, m_awid_o, m_arid_o, m_bid_i, m_rid_i;
  logic [27:0]  s_awaddr_i, s_araddr_i, m_awaddr_o, m_araddr_o;
  logic [7:0]   s_awlen_i, s_arlen_i, m_awlen_o, m_arlen_o, s_wstrb_i;
  logic [2:0]   s_awsize_i, s_arsize_i, m_awsize_o, m_arsize_o, s_awprot_i, s_arprot_i, m_awprot_o, m_arprot_o;
  logic [1:0]   s_awburst_i, s_arburst_i, m_awburst_o, m_arburst_o, s_bresp_o, s_rresp_o, m_bresp_i, m_rresp_i;
  logic [3:0]   s_awcache_i, s_arcache_i, m_awcache_o, m_arcache_o;
  logic         s_awlock_i, s_arlock_i, m_awlock_o, m_arlock_o;
  logic         s_awvalid_i, s_awready_o, s_wlast_i, s_wvalid_i, s_wready_o, s_bvalid_o, s_bready_i;
  logic         s_arvalid_i, s_arready_o, s_rlast_o, s_rvalid_o, s_rready_i;
  logic         m_awvalid_o, m_awready_i, m_wlast_o, m_wvalid_o, m_wready_i, m_bvalid_i, m_bready_o;
  logic         m_arvalid_o, m_arready_i, m_rlast_i, m_rvalid_i, m_rready_o;
  logic [63:0]  s_wdata_i, s_rdata_o;
  logic [127:0] m_wdata_o, m_rdata_i;
  logic [15:0]  m_wstrb_o;

  axi_mem_width_adapter dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_awid_i(s_awid_i), .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i), .s_awsize_i(s_awsize_i),
    .s_awburst_i(s_awburst_i), .s_awlock_i(s_awlock_i), .s_awcache_i(s_awcache_i), .s_awprot_i(s_awprot_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i), .s_wvalid_i(s_wvalid_i),
    .s_wready_o(s_wready_o),
    .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .s_arid_i(s_arid_i), .s_araddr_i(s_araddr_i), .s_arlen_i(s_arlen_i), .s_arsize_i(s_arsize_i),
    .s_arburst_i(s_arburst_i), .s_arlock_i(s_arlock_i), .s_arcache_i(s_arcache_i), .s_arprot_i(s_arprot_i),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rlast_o(s_rlast_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o),
    .m_awburst_o(m_awburst_o), .m_awlock_o(m_awlock_o), .m_awcache_o(m_awcache_o), .m_awprot_o(m_awprot_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i),
    .m_bid_i(m_bid_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
    .m_arburst_o(m_arburst_o), .m_arlock_o(m_arlock_o), .m_arcache_o(m_arcache_o), .m_arprot_o(m_arprot_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
  );

  typedef struct {
    int       addr;
    int       len;
    int       size;
    int       burst;
    logic [3:0] id;
  } txn_t;

  txn_t rq[$];
  txn_t wq[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input int addr, input int len, input int size, input int burst);
    txn_t t;
    t.addr = addr; t.len = len; t.size = size; t.burst = burst;
    t.id = 4'($urandom_range(0, 15));
    return t;
  endfunction

  // Address of beat n from AXI burst arithmetic.
  function automatic int beat_addr(input txn_t t, input int n);
    int bytes, total, base;
    bytes = 1 << t.size;
    if (t.burst == 0) return t.addr;
    if (t.burst == 2) begin
      total = (t.len + 1) * bytes;
      base  = t.addr - (t.addr % total);
      return base + ((t.addr - base + n * bytes) % total);
    end
    return t.addr + n * bytes;
  endfunction

  function automatic logic [63:0] exp_rdata(input logic [127:0] wd, input int a, input int size);
    logic [7:0]  by [16];
    logic [63:0] r;
    int lane, off, k;
    for (int i = 0; i < 16; i++) by[i] = wd[i*8 +: 8];
    lane = (a / 8) % 2;
    off  = a % 8;
    for (int i = 0; i < 8; i++) begin
      k = (size >= 3) ? i : off + (i % (1 << size));
      r[i*8 +: 8] = (k < 8) ? by[lane*8 + k] : 8'h00;
    end
    return r;
  endfunction

  function automatic txn_t rand_txn();
    int size, burst, len;
    size  = $urandom_range(0, 3);
    burst = $urandom_range(0, 2);
    len   = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 7);
    return mk($urandom_range(0, 4095) & ~((1 << size) - 1), len, size, burst);
  endfunction

  task automatic send_aw(input txn_t t);
    int tmo = 0;
    s_awid_i = t.id; s_awaddr_i = 28'(t.addr); s_awlen_i = 8'(t.len);
    s_awsize_i = 3'(t.size); s_awburst_i = 2'(t.burst); s_awvalid_i = 1'b1;
    @(negedge clk);
    while (!s_awready_o && tmo < 100) begin tmo++; @(negedge clk); end
    check("aw_accept", s_awready_o, 1);
    check("aw_pass", {m_awvalid_o, m_awid_o, m_awaddr_o, m_awlen_o, m_awsize_o, m_awburst_o},
          {1'b1, t.id, 28'(t.addr), 8'(t.len), 3'(t.size), 2'(t.burst)});
    @(posedge clk); #1;
    s_awvalid_i = 1'b0;
    if (tmo < 100) wq.push_back(t);
  endtask

  task automatic send_ar(input txn_t t);
    int tmo = 0;
    s_arid_i = t.id; s_araddr_i = 28'(t.addr); s_arlen_i = 8'(t.len);
    s_arsize_i = 3'(t.size); s_arburst_i = 2'(t.burst); s_arvalid_i = 1'b1;
    @(negedge clk);
    while (!s_arready_o && tmo < 100) begin tmo++; @(negedge clk); end
    check("ar_accept", s_arready_o, 1);
    check("ar_pass", {m_arvalid_o, m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o},
          {1'b1, t.id, 28'(t.addr), 8'(t.len), 3'(t.size), 2'(t.burst)});
    @(posedge clk); #1;
    s_arvalid_i = 1'b0;
    if (tmo < 100) rq.push_back(t);
  endtask

  task automatic wr_data(input int nb, input int fix_strb);
    txn_t t;
    int tmo, lane, last;
    logic [15:0] es;
    t = wq.pop_front();
    last = (nb < 0) ? t.len : nb - 1;
    for (int n = 0; n <= last; n++) begin
      s_wdata_i  = {$urandom(), $urandom()};
      s_wstrb_i  = (fix_strb >= 0) ? 8'(fix_strb) : 8'($urandom());
      s_wlast_i  = (n == t.len);
      s_wvalid_i = 1'b1;
      tmo = 0;
      @(negedge clk);
      while (!s_wready_o && tmo < 100) begin tmo++; @(negedge clk); end
      lane = (beat_addr(t, n) / 8) % 2;
      es = {8'h00, s_wstrb_i} << (lane * 8);
      check("w_data", m_wdata_o, {s_wdata_i, s_wdata_i});
      check("w_strb", m_wstrb_o, es);
      check("w_ctl", {s_wready_o, m_wvalid_o, m_wlast_o}, {2'b11, n == t.len});
      @(posedge clk); #1;
    end
    s_wvalid_i = 1'b0;
    s_wlast_i  = 1'b0;
  endtask

  task automatic ret_r(input logic fix_a5);
    txn_t t;
    int tmo;
    logic [127:0] wd;
    t = rq.pop_front();
    for (int n = 0; n <= t.len; n++) begin
      wd = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (fix_a5) wd[95:88] = 8'hA5;
      m_rid_i = t.id; m_rdata_i = wd; m_rresp_i = 2'($urandom_range(0, 3));
      m_rlast_i = (n == t.len); m_rvalid_i = 1'b1;
      tmo = 0;
      @(negedge clk);
      while (!s_rvalid_o && tmo < 100) begin tmo++; @(negedge clk); end
      check("r_data", s_rdata_o, exp_rdata(wd, beat_addr(t, n), t.size));
      if (fix_a5) check("r_byte_rep", s_rdata_o, 64'hA5A5A5A5A5A5A5A5);
      check("r_ctl", {s_rvalid_o, m_rready_o, s_rlast_o, s_rid_o, s_rresp_o},
            {2'b11, n == t.len, t.id, m_rresp_i});
      @(posedge clk); #1;
    end
    m_rvalid_i = 1'b0;
    m_rlast_i  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int k;
    s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0; s_wlast_i = 0;
    s_awid_i = 0; s_awaddr_i = 0; s_awlen_i = 0; s_awsize_i = 0; s_awburst_i = 0;
    s_arid_i = 0; s_araddr_i = 0; s_arlen_i = 0; s_arsize_i = 0; s_arburst_i = 0;
    s_awlock_i = 0; s_arlock_i = 0; s_awcache_i = 4'h3; s_arcache_i = 4'h3;
    s_awprot_i = 0; s_arprot_i = 0; s_wdata_i = 0; s_wstrb_i = 0;
    s_bready_i = 1; s_rready_i = 1;
    m_awready_i = 1; m_wready_i = 1; m_arready_i = 1;
    m_bvalid_i = 0; m_bid_i = 0; m_bresp_i = 0;
    m_rvalid_i = 0; m_rid_i = 0; m_rdata_i = 0; m_rresp_i = 0; m_rlast_i = 0;
    rst_i = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o,
                       m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o}, 10'd0);
    @(posedge clk); #1 rst_i = 0;
    @(negedge clk);
    check("post_rst_rdy", {s_awready_o, s_arready_o, s_wready_o, m_rready_o}, 4'b1100);
    @(posedge clk); #1;

    // Single beat into the upper lane.
    send_aw(mk(28'h08, 0, 3, 1));
    wr_data(-1, 8'hFF);
    // INCR and WRAP read lane sequencing, then a sub-word replicated read.
    send_ar(mk(28'h00, 3, 3, 1));
    ret_r(1'b0);
    m_rvalid_i = 1'b1;
    @(negedge clk);
    check("rfifo_empty_stall", {m_rready_o, s_rvalid_o}, 2'b00);
    @(posedge clk); #1 m_rvalid_i = 1'b0;
    send_ar(mk(28'h18, 3, 3, 2));
    ret_r(1'b0);
    send_ar(mk(28'h0B, 0, 0, 1));
    ret_r(1'b1);

    // Write response pass-through.
    m_bvalid_i = 1; m_bid_i = 4'h5; m_bresp_i = 2'b10; s_bready_i = 1;
    @(negedge clk);
    check("b_pass", {s_bvalid_o, s_bid_o, s_bresp_o, m_bready_o}, {1'b1, 4'h5, 2'b10, 1'b1});
    @(posedge clk); #1 s_bready_i = 0;
    @(negedge clk);
    check("b_bready", m_bready_o, 1'b0);
    @(posedge clk); #1 m_bvalid_i = 0; s_bready_i = 1;

    // Reset in the middle of a write burst with reads also pending.
    send_ar(mk(28'h20, 1, 3, 1));
    send_ar(mk(28'h40, 0, 3, 1));
    send_aw(mk(28'h10, 3, 3, 1));
    wr_data(2, -1);
    rst_i = 1; s_awvalid_i = 1; s_arvalid_i = 1; s_wvalid_i = 1; m_rvalid_i = 1; m_bvalid_i = 1;
    @(negedge clk);
    check("midrst_outs", {s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o,
                          m_awvalid_o, m_wvalid_o, m_arvalid_o, m_bready_o, m_rready_o}, 10'd0);
    @(posedge clk); #1;
    rst_i = 0; s_awvalid_i = 0; s_arvalid_i = 0; m_bvalid_i = 0;
    @(negedge clk);
    check("midrst_empty", {s_wready_o, m_wvalid_o, m_rready_o, s_rvalid_o, s_awready_o, s_arready_o},
          6'b000011);
    @(posedge clk); #1;
    s_wvalid_i = 0; m_rvalid_i = 0;
    rq.delete();
    wq.delete();
    send_aw(mk(28'h08, 3, 3, 1));
    wr_data(-1, -1);

    // Tracker depth: the fifth AR must wait until one burst completes.
    for (int i = 0; i < 4; i++) send_ar(mk(i * 8, $urandom_range(0, 3), 3, 1));
    t = mk(28'h30, 1, 3, 1);
    s_arid_i = t.id; s_araddr_i = 28'(t.addr); s_arlen_i = 8'(t.len);
    s_arsize_i = 3'(t.size); s_arburst_i = 2'(t.burst); s_arvalid_i = 1'b1;
    @(negedge clk);
    check("ar_full", {s_arready_o, m_arvalid_o}, 2'b00);
    @(posedge clk); #1;
    ret_r(1'b0);
    @(negedge clk);
    check("ar_reopen", {s_arready_o, m_arvalid_o}, 2'b11);
    @(posedge clk); #1 s_arvalid_i = 0;
    rq.push_back(t);
    for (int i = 0; i < 4; i++) ret_r(1'b0);

    // Randomized groups of in-flight bursts per direction.
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        for (int j = 0; j < k; j++) send_aw(rand_txn());
        for (int j = 0; j < k; j++) wr_data(-1, -1);
      end else begin
        for (int j = 0; j < k; j++) send_ar(rand_txn());
        for (int j = 0; j < k; j++) ret_r(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
